// File: rtl/sync_queue.sv
// Single-clock FIFO with valid/ready on both ports, a one-cycle flush and
// first-word-fall-through read data; used as the fetched-instruction buffer.
module sync_queue #(
  parameter int DATA_SIZE = 32,
  parameter int WIDTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 kill,
  output logic                 wready,
  input  logic                 wvalid,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 rready,
  output logic                 rvalid,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int DEPTH = 1 << WIDTH;

  logic [WIDTH:0]         head_q, head_d;
  logic [WIDTH:0]         tail_q, tail_d;
  logic [DATA_SIZE-1:0]   mem [DEPTH];

  logic empty;
  logic full;
  logic wr_fire;
  logic rd_fire;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign empty = (head_q == tail_q);
  assign full  = (head_q[WIDTH-1:0] == tail_q[WIDTH-1:0]) &&
                 (head_q[WIDTH] != tail_q[WIDTH]);

  assign wready = !full;
  assign rvalid = !empty;
  assign rdata  = rvalid ? mem[head_q[WIDTH-1:0]] : '0;

  assign wr_fire = wvalid && wready && !kill;
  assign rd_fire = rready && rvalid && !kill;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (kill) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (wr_fire) tail_d = tail_q + 1'b1;
      if (rd_fire) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage has no reset; occupancy is defined solely by the pointers
  always_ff @(posedge clk) begin
    if (wr_fire) mem[tail_q[WIDTH-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_sync_queue.sv
// Self-checking bench for sync_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model by an independent monitor.
module tb_sync_queue;

  localparam int DATA_SIZE = 32;
  localparam int WIDTH     = 2;
  localparam int DEPTH     = 1 << WIDTH;

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b1;
  logic                 kill   = 1'b0;
  logic                 wvalid = 1'b0;
  logic [DATA_SIZE-1:0] wdata  = '0;
  logic                 rready = 1'b0;
  logic                 wready;
  logic                 rvalid;
  logic [DATA_SIZE-1:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_SIZE-1:0] ref_q [$];
  bit m_wf;
  bit m_rf;

  sync_queue #(.DATA_SIZE(DATA_SIZE), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (kill),
    .wready (wready),
    .wvalid (wvalid),
    .wdata  (wdata),
    .rready (rready),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DATA_SIZE-1:0] actual,
                             input logic [DATA_SIZE-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Inputs change 2 time units after the edge so they are stable at the next edge
  task automatic applyStimulus(input logic wv, input logic [DATA_SIZE-1:0] wd,
                               input logic rr, input logic k);
    wvalid = wv;
    wdata  = wd;
    rready = rr;
    kill   = k;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a plain queue of stored entries, capacity DEPTH
  always @(posedge clk) begin
    if (rst_n) begin
      if (kill) begin
        ref_q.delete();
      end else begin
        m_wf = wvalid && (ref_q.size() < DEPTH);
        m_rf = rready && (ref_q.size() > 0);
        if (m_rf) void'(ref_q.pop_front());
        if (m_wf) ref_q.push_back(wdata);
      end
    end
  end

  always @(negedge rst_n) ref_q.delete();

  // Monitor: compares the presented outputs against the model mid-cycle
  always @(negedge clk) begin
    checkOutput("mon_rvalid", {31'd0, rvalid}, {31'd0, ref_q.size() > 0});
    checkOutput("mon_wready", {31'd0, wready}, {31'd0, ref_q.size() < DEPTH});
    checkOutput("mon_rdata", rdata, (ref_q.size() > 0) ? ref_q[0] : '0);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("reset_wready", {31'd0, wready}, 32'd1);
    checkOutput("reset_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic ordering
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
    checkOutput("t1_first_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("t1_first_rdata", rdata, 32'hA5);
    applyStimulus(1'b1, 32'h5A, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
    checkOutput("t1_rd0", rdata, 32'hA5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_rd1", rdata, 32'h5A);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_rd2", rdata, 32'h33);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_empty_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("t1_empty_rdata", rdata, 32'd0);

    // Fill to capacity, then hold a blocked write
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    checkOutput("t2_full_wready", {31'd0, wready}, 32'd0);
    applyStimulus(1'b1, 32'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd9, 1'b0, 1'b0);
    checkOutput("t2_still_full", {31'd0, wready}, 32'd0);
    checkOutput("t2_rd1", rdata, 32'd1);
    applyStimulus(1'b1, 32'd9, 1'b1, 1'b0);
    checkOutput("t2_wready_back", {31'd0, wready}, 32'd1);
    applyStimulus(1'b1, 32'd9, 1'b0, 1'b0);
    checkOutput("t2_full_again", {31'd0, wready}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("t2_drain", rdata, (i < 3) ? (i + 2) : 32'd9);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("t2_drained", {31'd0, rvalid}, 32'd0);

    // Streaming with simultaneous read and write
    for (int i = 0; i <= 40; i++) begin
      applyStimulus(1'b1, i, 1'b1, 1'b0);
      checkOutput("t3_stream_rdata", rdata, i);
      checkOutput("t3_stream_wready", {31'd0, wready}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_stream_end", {31'd0, rvalid}, 32'd0);

    // Kill beats simultaneous write and read
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b1);
    checkOutput("t4_kill_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("t4_kill_wready", {31'd0, wready}, 32'd1);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    checkOutput("t4_after_kill", rdata, 32'h11);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t4_only_entry", {31'd0, rvalid}, 32'd0);

    // Asynchronous reset mid-stream
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b0, 1'b0);
    wvalid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("t5_async_wready", {31'd0, wready}, 32'd1);
    checkOutput("t5_async_rdata", rdata, 32'd0);
    applyStimulus(1'b1, 32'hDD, 1'b1, 1'b1);
    checkOutput("t5_held_rvalid", {31'd0, rvalid}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b0);
    checkOutput("t5_post_reset", rdata, 32'hBEEF);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_queue.md
# sync_queue

Synchronous single-clock FIFO with valid/ready handshakes on both ports and a one-cycle flush input. Its main use is as the fetched-instruction buffer between instruction memory responses and the decode stage. The flush is driven on branch-misprediction redirects. Width and depth are parameterised, with first-word-fall-through read data.

## Interface
- `DATA_SIZE`, default 32: entry width in bits.
- `WIDTH`, default 4: address width. Capacity is exactly 2^WIDTH entries.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. Clears pointers and count only; storage is not reset.
- `kill`  in  1  synchronous flush: queue becomes empty at the next edge.
- `wready`  out  1  queue can accept an entry (not full).
- `wvalid`  in  1  producer offers `wdata`.
- `wdata`  in  DATA_SIZE  entry to enqueue.
- `rready`  in  1  consumer accepts head entry.
- `rvalid`  out  1  queue holds at least one entry (not empty).
- `rdata`  out  DATA_SIZE  head entry; all-zero when `rvalid`=0.

## Operation
- State:
  - head and tail pointers, each WIDTH+1 bits; the extra bit is a wrap flag.
  - Storage array of 2^WIDTH × DATA_SIZE.
- Empty when head == tail, all bits.
- Full when the low WIDTH bits are equal and the wrap bits differ.
- Outputs:
  - `wready` = !full, combinational from registered state only.
  - `rvalid` = !empty.
  - `rdata` = rvalid ? storage[head] : 0.
  - None of these depend on `wvalid`, `rready` or `kill` (no combinational paths from inputs).
- Write fires when `wvalid & wready`: storage[tail] <= wdata, tail <= tail+1.
- Read fires when `rvalid & rready`: head <= head+1.
- Simultaneous write and read in the same cycle:
  - Both fire when their conditions hold; occupancy is unchanged.
  - When full, `wready`=0, so no write occurs even if a read fires. There is no pass-through.
  - When empty, `rvalid`=0, so no read occurs; the write lands and is readable next cycle.
- `wvalid` with `wready`=0, or `rready` with `rvalid`=0, is ignored with no side effects.
- Kill:
  - `kill`=1 sets head <= 0 and tail <= 0 at the edge.
  - Any write or read handshake in the same cycle is discarded.
  - Kill has priority over both handshakes.
- Pointers wrap modulo 2^(WIDTH+1). The storage index is the low WIDTH bits.
- Reset (`rst_n`=0, asynchronous):
  - head = tail = 0 immediately, so `rvalid`=0, `wready`=1, `rdata`=0.
  - This state is held while `rst_n` is low. Reset overrides kill and all handshakes.

## Timing
- Write-to-read latency: 1 cycle. An entry written at edge N is visible on `rdata` with `rvalid`=1 after edge N.
- The head entry is presented combinationally. A read at edge N exposes the next entry immediately after edge N.
- `wready` deasserts the cycle after the 2^WIDTH-th unread entry is written. It reasserts the cycle after any read from full.
- After `kill` at edge N: `rvalid`=0 and `wready`=1 from edge N onward. New writes are accepted in cycle N+1.
- Sustained throughput is one write plus one read per cycle when neither full nor empty.
- Reset release: the first write is accepted in the first cycle with `rst_n`=1.

## Test plan
- Reset, then write 0xA5, 0x5A, 0x33 on consecutive cycles with `rready`=0:
  - `rvalid` rises one cycle after the first write, with `rdata`=0xA5.
  - Reading three times yields 0xA5, 0x5A, 0x33 in order, then `rvalid`=0 and `rdata`=0.
- Fill (WIDTH=2) with 1..4, then hold `wvalid`=1 with value 9:
  - `wready`=0 after the 4th write; 9 is never enqueued.
  - One read returns 1; `wready`=1 the next cycle; 9 is then accepted.
  - The remaining reads yield 2, 3, 4, 9.
- Continuous streaming of 0..40 with `wvalid`=`rready`=1 (WIDTH=2, exercises pointer wrap several times):
  - Reads return 0..40 in order, one per cycle.
  - Occupancy never exceeds 1.
  - `wready` stays 1 throughout.
- With 3 entries queued, assert `kill` together with `wvalid`=1 (0x77) and `rready`=1:
  - Next cycle `rvalid`=0 and `wready`=1; 0x77 is not present.
  - A subsequent write of 0x11 is read back as the next and only entry.
- Assert `rst_n`=0 asynchronously mid-stream with 2 entries held:
  - `rvalid`=0, `wready`=1 and `rdata`=0 before the next clock edge.
  - After release, the queue behaves as freshly reset.
